// File: rtl/imm_gen_pipe.sv
// RISC-V immediate decoder with a two-entry (output + skid) registered
// pipeline stage carrying an opaque tag alongside each instruction.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);
    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;
    localparam logic [2:0] FMT_ZIMM  = 3'd7;

    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_fmt;
    logic            w_ill;
    logic [2:0]      w_f3;
    logic            w_is_shift;

    assign w_f3       = in_inst[14:12];
    assign w_is_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);
    assign w_imm_i    = XLEN'($signed(in_inst[31:20]));
    assign w_imm_s    = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
    assign w_imm_b    = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
    assign w_imm_u    = XLEN'($signed({in_inst[31:12], 12'b0}));
    assign w_imm_j    = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));

    always_comb begin
        w_imm = '0;
        w_fmt = FMT_NONE;
        w_ill = 1'b0;
        if (in_inst[1:0] != 2'b11) begin
            w_ill = 1'b1;
        end else begin
            case (in_inst[6:0])
                7'b0000011, 7'b1100111: begin w_fmt = FMT_I; w_imm = w_imm_i; end
                7'b0100011: begin w_fmt = FMT_S; w_imm = w_imm_s; end
                7'b1100011: begin w_fmt = FMT_B; w_imm = w_imm_b; end
                7'b0110111, 7'b0010111: begin w_fmt = FMT_U; w_imm = w_imm_u; end
                7'b1101111: begin w_fmt = FMT_J; w_imm = w_imm_j; end
                7'b0010011: begin
                    if (!w_is_shift) begin
                        w_fmt = FMT_I;
                        w_imm = w_imm_i;
                    end else begin
                        w_fmt = FMT_SHAMT;
                        if (XLEN == 64) w_imm = XLEN'(in_inst[25:20]);
                        else if (in_inst[25]) w_ill = 1'b1;
                        else w_imm = XLEN'(in_inst[24:20]);
                    end
                end
                7'b0011011: begin
                    // Word-sized ops only exist on RV64; shift amount is 5 bits.
                    if (XLEN != 64) begin
                        w_ill = 1'b1;
                    end else if (!w_is_shift) begin
                        w_fmt = FMT_I;
                        w_imm = w_imm_i;
                    end else begin
                        w_fmt = FMT_SHAMT;
                        if (in_inst[25]) w_ill = 1'b1;
                        else w_imm = XLEN'(in_inst[24:20]);
                    end
                end
                7'b1110011: begin
                    if (w_f3[2] && (w_f3[1:0] != 2'b00)) begin
                        w_fmt = FMT_ZIMM;
                        w_imm = XLEN'(in_inst[19:15]);
                    end else if (w_f3 == 3'b100) begin
                        w_ill = 1'b1;
                    end
                end
                7'b0110011, 7'b0001111: ;
                7'b0111011: w_ill = (XLEN != 64);
                default: w_ill = 1'b1;
            endcase
        end
    end

    logic             r_o_valid, r_s_valid;
    logic [XLEN-1:0]  r_o_imm, r_s_imm;
    logic [2:0]       r_o_fmt, r_s_fmt;
    logic             r_o_ill, r_s_ill;
    logic [TAG_W-1:0] r_o_tag, r_s_tag;
    logic             w_in_fire, w_out_fire;

    assign in_ready    = !r_s_valid;
    assign w_in_fire   = in_valid && in_ready;
    assign w_out_fire  = r_o_valid && out_ready;
    assign out_valid   = r_o_valid;
    assign out_imm     = r_o_imm;
    assign out_fmt     = r_o_fmt;
    assign out_illegal = r_o_ill;
    assign out_tag     = r_o_tag;

    // S is only ever filled while O is held, so S valid implies no input fire.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_o_valid <= 1'b0;
            r_o_imm   <= '0;
            r_o_fmt   <= FMT_NONE;
            r_o_ill   <= 1'b0;
            r_o_tag   <= '0;
            r_s_valid <= 1'b0;
            r_s_imm   <= '0;
            r_s_fmt   <= FMT_NONE;
            r_s_ill   <= 1'b0;
            r_s_tag   <= '0;
        end else if (w_out_fire && r_s_valid) begin
            r_o_imm   <= r_s_imm;
            r_o_fmt   <= r_s_fmt;
            r_o_ill   <= r_s_ill;
            r_o_tag   <= r_s_tag;
            r_s_valid <= 1'b0;
        end else if (w_out_fire || !r_o_valid) begin
            r_o_valid <= w_in_fire;
            if (w_in_fire) begin
                r_o_imm <= w_imm;
                r_o_fmt <= w_fmt;
                r_o_ill <= w_ill;
                r_o_tag <= in_tag;
            end
        end else if (w_in_fire) begin
            r_s_valid <= 1'b1;
            r_s_imm   <= w_imm;
            r_s_fmt   <= w_fmt;
            r_s_ill   <= w_ill;
            r_s_tag   <= in_tag;
        end
    end
endmodule
